// File: rtl/ctrl_pkg.sv
// Shared definitions for the control unit: FSM state encoding, opcode
// constants, ALU select and PC source encodings, plus a helper mapping
// arithmetic/logic opcodes onto their ALU select code.
package ctrl_pkg;

  typedef enum logic [1:0] {
    ST_FETCH   = 2'b00,
    ST_DECODE  = 2'b01,
    ST_EXECUTE = 2'b10,
    ST_HALT    = 2'b11
  } state_t;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDI = 4'h1;
  localparam logic [3:0] OP_LDA = 4'h2;
  localparam logic [3:0] OP_STA = 4'h3;
  localparam logic [3:0] OP_ADD = 4'h4;
  localparam logic [3:0] OP_SUB = 4'h5;
  localparam logic [3:0] OP_AND = 4'h6;
  localparam logic [3:0] OP_OR  = 4'h7;
  localparam logic [3:0] OP_XOR = 4'h8;
  localparam logic [3:0] OP_NOT = 4'h9;
  localparam logic [3:0] OP_SHL = 4'hA;
  localparam logic [3:0] OP_SHR = 4'hB;
  localparam logic [3:0] OP_JMP = 4'hC;
  localparam logic [3:0] OP_JZ  = 4'hD;
  localparam logic [3:0] OP_JR  = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  // ALU select: 0000..0111 are the arithmetic/logic ops in opcode order,
  // the two pass-through selects feed the accumulator from imm or a register.
  localparam logic [3:0] ALU_NONE     = 4'b0000;
  localparam logic [3:0] ALU_PASS_IMM = 4'b1000;
  localparam logic [3:0] ALU_PASS_REG = 4'b1001;

  // PC load source; 10/11 are reserved and never driven.
  localparam logic [1:0] SEL_PC_IMM = 2'b00;
  localparam logic [1:0] SEL_PC_REG = 2'b01;

  // ADD..SHR are contiguous, so the ALU code is simply the offset from ADD.
  function automatic logic [3:0] alu_sel_of(input logic [3:0] opc);
    return opc - OP_ADD;
  endfunction

endpackage

// File: rtl/control_unit_if.sv
// Bus between the control unit and the datapath.
//   op, z, c             : datapath -> control (opcode field, held flags)
//   LoadIR..SelALU       : control -> datapath strobes and selects
//   phase, halted        : control -> observer (debug state code, halt flag)
// Handshake: none; every strobe is a single-cycle command qualified only by
// the clock, and the datapath acts on it at the next rising edge.
interface control_unit_if;
  logic [3:0] op;
  logic       z;
  logic       c;
  logic       LoadIR;
  logic       IncPC;
  logic       LoadPC;
  logic [1:0] SelPC;
  logic       LoadReg;
  logic       LoadAcc;
  logic [3:0] SelALU;
  logic [1:0] phase;
  logic       halted;

  modport master (
    output op, z, c,
    input  LoadIR, IncPC, LoadPC, SelPC, LoadReg, LoadAcc, SelALU, phase, halted
  );

  modport slave (
    input  op, z, c,
    output LoadIR, IncPC, LoadPC, SelPC, LoadReg, LoadAcc, SelALU, phase, halted
  );
endinterface

// File: rtl/op_decoder.sv
// Combinational EXECUTE-phase decode table.
//   op      : opcode
//   z       : accumulator zero flag (only JZ looks at it)
//   load_pc, load_reg, load_acc : strobes requested by the opcode
//   sel_pc, sel_alu             : selects, zero whenever their strobe is low
module op_decoder
  import ctrl_pkg::*;
(
  input  logic [3:0] op,
  input  logic       z,
  output logic       load_pc,
  output logic       load_reg,
  output logic       load_acc,
  output logic [1:0] sel_pc,
  output logic [3:0] sel_alu
);

  always_comb begin
    load_pc  = 1'b0;
    load_reg = 1'b0;
    load_acc = 1'b0;
    sel_pc   = SEL_PC_IMM;
    sel_alu  = ALU_NONE;
    case (op)
      OP_LDI: begin load_acc = 1'b1; sel_alu = ALU_PASS_IMM; end
      OP_LDA: begin load_acc = 1'b1; sel_alu = ALU_PASS_REG; end
      OP_STA: load_reg = 1'b1;
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_SHL, OP_SHR: begin
        load_acc = 1'b1;
        sel_alu  = alu_sel_of(op);
      end
      OP_JMP: load_pc = 1'b1;
      OP_JZ:  load_pc = z;
      OP_JR:  begin load_pc = 1'b1; sel_pc = SEL_PC_REG; end
      default: ; // NOP and HLT issue nothing here
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Three-phase (FETCH/DECODE/EXECUTE) instruction sequencer with optional HALT.
//   clk         : system clock, rising edge
//   CLB         : asynchronous active-low reset
//   bus (slave) : op/z/c in; LoadIR, IncPC, LoadPC, SelPC, LoadReg, LoadAcc,
//                 SelALU, phase (state code) and halted out
// ENABLE_HALT = 1 makes HLT enter an absorbing HALT state; 0 runs it as NOP.
module control_unit
  import ctrl_pkg::*;
#(
  parameter bit ENABLE_HALT = 1'b1
) (
  input  logic           clk,
  input  logic           CLB,
  control_unit_if.slave  bus
);

  state_t state_q, state_d;

  logic       dec_load_pc;
  logic       dec_load_reg;
  logic       dec_load_acc;
  logic [1:0] dec_sel_pc;
  logic [3:0] dec_sel_alu;
  logic       in_exec;
  logic       carry_unused;

  // No opcode branches on carry; the flag is accepted on the bus only.
  assign carry_unused = bus.c;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH:   state_d = ST_DECODE;
      ST_DECODE:  state_d = ST_EXECUTE;
      ST_EXECUTE: state_d = (ENABLE_HALT && (bus.op == OP_HLT)) ? ST_HALT : ST_FETCH;
      ST_HALT:    state_d = ST_HALT;
    endcase
  end

  always_ff @(posedge clk or negedge CLB) begin
    if (!CLB) state_q <= ST_FETCH;
    else      state_q <= state_d;
  end

  op_decoder u_op_decoder (
    .op       (bus.op),
    .z        (bus.z),
    .load_pc  (dec_load_pc),
    .load_reg (dec_load_reg),
    .load_acc (dec_load_acc),
    .sel_pc   (dec_sel_pc),
    .sel_alu  (dec_sel_alu)
  );

  // Outputs are gated by CLB so that, while reset is held, the FETCH state
  // does not leak a LoadIR and an abandoned instruction issues nothing.
  assign in_exec     = CLB && (state_q == ST_EXECUTE);
  assign bus.LoadIR  = CLB && (state_q == ST_FETCH);
  assign bus.IncPC   = CLB && (state_q == ST_DECODE);
  assign bus.LoadPC  = in_exec && dec_load_pc;
  assign bus.LoadReg = in_exec && dec_load_reg;
  assign bus.LoadAcc = in_exec && dec_load_acc;
  assign bus.SelPC   = in_exec ? dec_sel_pc  : SEL_PC_IMM;
  assign bus.SelALU  = in_exec ? dec_sel_alu : ALU_NONE;
  assign bus.phase   = state_q;
  assign bus.halted  = CLB && (state_q == ST_HALT);

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have parameter ENABLE_HALT, default 1: 1 = opcode HLT halts the core; 0 = HLT executes as NOP.
REQ-002 SHALL have port clk  in  1  single system clock; all state updates on rising edge.
REQ-003 SHALL have port CLB  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port op  in  4  opcode field of the instruction register (IR[7:4]).
REQ-005 SHALL have port z  in  1  accumulator zero flag, held by the datapath.
REQ-006 SHALL have port c  in  1  accumulator carry flag, held by the datapath.
REQ-007 SHALL have port LoadIR  out  1  IR load strobe.
REQ-008 SHALL have port IncPC  out  1  PC increment strobe.
REQ-009 SHALL have port LoadPC  out  1  PC parallel-load strobe.
REQ-010 SHALL have port SelPC  out  2  PC load source: 00 imm, 01 register value, 10/11 reserved (never driven).
REQ-011 SHALL have port LoadReg  out  1  register-file write strobe (register addressed by IR[3:0], data from accumulator).
REQ-012 SHALL have port LoadAcc  out  1  accumulator load strobe (from ALU result).
REQ-013 SHALL have port SelALU  out  4  ALU operation select.
REQ-014 SHALL have port phase  out  2  current FSM state code, for debug.
REQ-015 SHALL have port halted  out  1  high while in HALT.

Function
REQ-016 SHALL implement FSM states FETCH=00, DECODE=01, EXECUTE=10, HALT=11.
REQ-017 SHALL transition FETCH->DECODE->EXECUTE->FETCH every clock, so each instruction takes exactly 3 cycles.
REQ-018 SHALL in EXECUTE with op=HLT (1111) and ENABLE_HALT=1 transition to HALT; HALT SHALL be absorbing until reset.
REQ-019 SHALL drive outputs combinationally from state and op; each strobe high for exactly one cycle per instruction where applicable.
REQ-020 SHALL in FETCH assert LoadIR only.
REQ-021 SHALL in DECODE assert IncPC only, so PC points to the next instruction before EXECUTE.
REQ-022 SHALL in EXECUTE decode op as: 0 NOP none; 1 LDI LoadAcc, SelALU=1000 (pass imm); 2 LDA LoadAcc, SelALU=1001 (pass reg); 3 STA LoadReg; 4 ADD/5 SUB/6 AND/7 OR/8 XOR/9 NOT/A SHL/B SHR LoadAcc, SelALU=op-4 (0000..0111); C JMP LoadPC, SelPC=00; D JZ LoadPC, SelPC=00 only if z=1; E JR LoadPC, SelPC=01; F HLT none.
REQ-023 SHALL sample z and c only in EXECUTE; flag values are those left by the previous instruction.
REQ-024 SHALL never assert LoadPC and IncPC in the same cycle, nor LoadAcc and LoadReg in the same cycle.
REQ-025 SHALL hold SelALU=0000 and SelPC=00 whenever the matching strobe is low.
REQ-026 SHALL in HALT drive all strobes 0, halted=1, phase=11.
REQ-027 SHALL treat the flag inputs as don't-care for every op other than JZ.

Reset
REQ-028 SHALL on CLB low immediately (asynchronously) enter FETCH and force all strobes, SelPC, SelALU and halted to 0 while CLB is low.
REQ-029 SHALL, after CLB rises, issue LoadIR on the first rising edge's cycle (FETCH) and proceed normally.
REQ-030 SHALL abandon an in-flight instruction on reset mid-DECODE/EXECUTE without issuing its remaining strobes.

Structure
REQ-031 SHALL take opcode constants, SelALU encodings, SelPC encodings and the state encoding from shared package ctrl_pkg.
REQ-032 SHALL place the EXECUTE decode table in a combinational sub-module op_decoder (inputs op, z; outputs strobes, SelPC, SelALU).

Verification
REQ-033 SHALL verify reset: CLB=0 mid-EXECUTE with op=4 -> LoadAcc drops at once, phase=00; after release LoadIR=1 in the first cycle.
REQ-034 SHALL verify sequencing: op=4 stream -> LoadIR, IncPC, LoadAcc+SelALU=0000 on cycles 1,2,3, repeating with period 3.
REQ-035 SHALL verify branches: op=D, z=0 -> no LoadPC in EXECUTE; op=D, z=1 -> LoadPC=1, SelPC=00; op=E -> LoadPC=1, SelPC=01.
REQ-036 SHALL verify halt: op=F, ENABLE_HALT=1 -> phase=11, halted=1, all strobes 0 for 20 cycles; ENABLE_HALT=0 -> next FETCH follows.
REQ-037 SHALL verify the full table: all 16 opcodes x z,c in {0,1} -> EXECUTE outputs match REQ-022 and REQ-024 hold every cycle.
